// File: rtl/cordic_pkg.sv
// Shared types and constants for the cordic_360 scheduler and its response FIFO.
// Angle codes span one full circle in FULL_CIRCLE steps.
package cordic_pkg;

  localparam int ANGLE_W     = 12;
  localparam int DATA_W      = 12;
  localparam int ID_W        = 3;
  localparam int QUARTER     = 803;
  localparam int FULL_CIRCLE = 4 * QUARTER;

  typedef struct packed {
    logic [ID_W-1:0]          id;
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] y;
  } cordic_rsp_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  // One conditional subtraction is enough because 2*FULL_CIRCLE exceeds the 12-bit code space.
  function automatic logic [ANGLE_W-1:0] wrap_angle(input logic [ANGLE_W-1:0] a);
    return (a >= ANGLE_W'(FULL_CIRCLE)) ? a - ANGLE_W'(FULL_CIRCLE) : a;
  endfunction

endpackage

// File: rtl/cordic_rsp_fifo.sv
// First-word fall-through response FIFO for cordic_sched; DEPTH must be a power of 2.
// Output data reads as zero while empty.
module cordic_rsp_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push_i,
  input  cordic_rsp_t push_data_i,
  input  logic        pop_i,
  output cordic_rsp_t pop_data_o,
  output logic [AW:0] count_o
);

  cordic_rsp_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // A pop on a full FIFO frees the slot being written in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
    if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  // NOTE: storage is not reset; the count and pointers alone decide what is valid,
  // and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign pop_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;

endmodule

// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one cordic_360 engine between N_REQ requesters.
// Optional build macro CORDIC_ANGLE_WRAP_EN folds angles >= FULL_CIRCLE back into range.
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int CORDIC_LAT = 18,
  parameter int RSP_DEPTH  = 8,
  localparam int RID_W     = $clog2(N_REQ)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [ANGLE_W*N_REQ-1:0]   req_angle,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       cordic_ce,
  output logic [ANGLE_W-1:0]         cordic_angle,
  input  logic signed [DATA_W-1:0]   cordic_x,
  input  logic signed [DATA_W-1:0]   cordic_y,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [RID_W-1:0]           rsp_id,
  output logic signed [DATA_W-1:0]   rsp_x,
  output logic signed [DATA_W-1:0]   rsp_y
);

  localparam int CRED_W   = $clog2(RSP_DEPTH + 1);
  localparam int PIPE_LEN = CORDIC_LAT + 1;
  localparam int CNT_W    = $clog2(RSP_DEPTH) + 1;

  logic [RID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CRED_W-1:0]  credits_q, credits_d;
  logic [ANGLE_W-1:0] cordic_angle_q, cordic_angle_d;
  tag_t               tag_q [PIPE_LEN];

  logic [N_REQ-1:0]   grant;
  logic [RID_W-1:0]   grant_idx;
  logic               issue;
  logic [ANGLE_W-1:0] angle_sel;
  logic               pop;
  logic               push;
  cordic_rsp_t        push_data, head;
  logic [CNT_W-1:0]   fifo_count;
  logic               unused_id;

  function automatic int rr_index(input logic [RID_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    return (sum >= N_REQ) ? sum - N_REQ : sum;
  endfunction

  // NOTE: every combinational output gets a default before any branch, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    issue     = 1'b0;
    if (!reset && (credits_q != '0)) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!issue && req_valid[rr_index(rr_ptr_q, i)]) begin
          issue                        = 1'b1;
          grant_idx                    = RID_W'(rr_index(rr_ptr_q, i));
          grant[rr_index(rr_ptr_q, i)] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    angle_sel = req_angle[int'(grant_idx)*ANGLE_W +: ANGLE_W];
`ifdef CORDIC_ANGLE_WRAP_EN
    angle_sel = wrap_angle(angle_sel);
`endif
  end

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    credits_d      = credits_q;
    cordic_angle_d = cordic_angle_q;
    if (issue) begin
      rr_ptr_d       = (grant_idx == RID_W'(N_REQ - 1)) ? '0 : grant_idx + RID_W'(1);
      cordic_angle_d = angle_sel;
    end
    if (issue && !pop) credits_d = credits_q - CRED_W'(1);
    if (pop && !issue) credits_d = credits_q + CRED_W'(1);
  end

  // NOTE: registers use non-blocking assignments so every stage of the tag pipe
  // samples its predecessor's old value, giving a true shift register.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q       <= '0;
      credits_q      <= CRED_W'(RSP_DEPTH);
      cordic_angle_q <= '0;
      for (int i = 0; i < PIPE_LEN; i++) tag_q[i] <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      credits_q      <= credits_d;
      cordic_angle_q <= cordic_angle_d;
      tag_q[0]       <= '{valid: issue, id: ID_W'(grant_idx)};
      for (int i = 1; i < PIPE_LEN; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // The tag leaves the pipe in the same cycle the engine presents the matching result.
  assign push      = tag_q[PIPE_LEN-1].valid;
  assign push_data = '{id: tag_q[PIPE_LEN-1].id, x: cordic_x, y: cordic_y};

  cordic_rsp_fifo #(
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_data_o  (head),
    .count_o     (fifo_count)
  );

  assign rsp_valid    = (fifo_count != '0);
  assign pop          = rsp_valid && rsp_ready;
  assign rsp_id       = head.id[RID_W-1:0];
  assign rsp_x        = head.x;
  assign rsp_y        = head.y;
  assign unused_id    = ^head.id;

  assign req_ready    = grant;
  assign cordic_angle = cordic_angle_q;
  assign cordic_ce    = !reset;

endmodule

// File: tb/tb_cordic_sched.sv
// Self-checking bench for cordic_sched with a behavioural stand-in for the cordic_360 engine.
// Directed scenarios plus a randomised scoreboard run.
module tb_cordic_sched;

  localparam int N     = 4;
  localparam int LAT   = 18;
  localparam int DEPTH = 8;

  logic                clock = 1'b0;
  logic                reset;
  logic [N-1:0]        req_valid;
  logic [12*N-1:0]     req_angle;
  logic [N-1:0]        req_ready;
  logic                cordic_ce;
  logic [11:0]         cordic_angle;
  logic signed [11:0]  cordic_x, cordic_y;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [1:0]          rsp_id;
  logic signed [11:0]  rsp_x, rsp_y;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  cordic_sched #(
    .N_REQ      (N),
    .CORDIC_LAT (LAT),
    .RSP_DEPTH  (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_angle    (req_angle),
    .req_ready    (req_ready),
    .cordic_ce    (cordic_ce),
    .cordic_angle (cordic_angle),
    .cordic_x     (cordic_x),
    .cordic_y     (cordic_y),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_x        (rsp_x),
    .rsp_y        (rsp_y)
  );

  // Engine stand-in: amplitude 511, out-of-range angles give a -2048 marker.
  function automatic int model_val(input int a, input bit want_sin);
    real th, v;
    if (a >= 3212) return -2048;
    th = 2.0 * 3.14159265358979 * $itor(a) / 3212.0;
    v  = 511.0 * (want_sin ? $sin(th) : $cos(th));
    return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
  endfunction

  logic signed [11:0] ex_q [LAT];
  logic signed [11:0] ey_q [LAT];

  always @(posedge clock) begin
    if (cordic_ce) begin
      ex_q[0] <= 12'(model_val(int'(cordic_angle), 1'b0));
      ey_q[0] <= 12'(model_val(int'(cordic_angle), 1'b1));
      for (int i = 1; i < LAT; i++) begin
        ex_q[i] <= ex_q[i-1];
        ey_q[i] <= ey_q[i-1];
      end
    end
  end
  assign cordic_x = ex_q[LAT-1];
  assign cordic_y = ey_q[LAT-1];

  typedef struct {
    int cyc;
    int id;
    int a;
    int x;
    int y;
  } ev_t;

  ev_t g_q[$];
  ev_t r_q[$];

  // Mid-cycle monitor: logs handshakes and checks the grant is at most one-hot.
  always @(negedge clock) begin
    if (!reset) begin
      total++;
      if ($countones(req_ready) > 1) begin
        bad++;
        $display("FAIL onehot: req_ready=%b expected at most one bit", req_ready);
      end
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i])
          g_q.push_back('{cyc, i, int'(req_angle[i*12 +: 12]), 0, 0});
      if (rsp_valid && rsp_ready)
        r_q.push_back('{cyc, int'(rsp_id), 0, int'(rsp_x), int'(rsp_y)});
    end
  end

  function automatic bit near(input int a, input int b);
    return ((a - b) <= 2) && ((b - a) <= 2);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_req(input int id, input bit v, input int a);
    req_valid[id]         = v;
    req_angle[id*12 +: 12] = 12'(a);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_angle = '0;
    rsp_ready = 1'b0;
    tick(2);
    reset = 1'b0;
    g_q.delete();
    r_q.delete();
  endtask

  task automatic wait_grants(input int n, input int limit, input string name);
    int k = 0;
    while (g_q.size() < n && k < limit) begin
      tick();
      k++;
    end
    total++;
    if (g_q.size() < n) begin
      bad++;
      $display("FAIL %s grant wait: got %0d grants, expected %0d", name, g_q.size(), n);
    end
  endtask

  task automatic wait_rsps(input int n, input int limit, input string name);
    int k = 0;
    while (r_q.size() < n && k < limit) begin
      tick();
      k++;
    end
    total++;
    if (r_q.size() < n) begin
      bad++;
      $display("FAIL %s rsp wait: got %0d responses, expected %0d", name, r_q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '1;
    req_angle = {12'd5, 12'd6, 12'd7, 12'd8};
    rsp_ready = 1'b1;
    tick(2);
    @(negedge clock);
    total += 6;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    if (cordic_ce !== 1'b0) begin bad++; $display("FAIL reset_ce: got %b expected 0", cordic_ce); end
    if (cordic_angle !== 12'd0) begin bad++; $display("FAIL reset_angle: got %0d expected 0", cordic_angle); end
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    if (rsp_x !== 12'sd0 || rsp_y !== 12'sd0) begin
      bad++; $display("FAIL reset_rsp_xy: got %0d,%0d expected 0,0", rsp_x, rsp_y);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 0);
    wait_grants(1, 10, "single");
    req_valid = '0;
    wait_rsps(1, 3 * LAT, "single");
    if (r_q.size() < 1 || g_q.size() < 1) return;
    total += 4;
    if (r_q[0].cyc - g_q[0].cyc != LAT + 2) begin
      bad++; $display("FAIL single_latency: got %0d cycles expected %0d", r_q[0].cyc - g_q[0].cyc, LAT + 2);
    end
    if (r_q[0].id != 0) begin bad++; $display("FAIL single_id: got %0d expected 0", r_q[0].id); end
    if (!near(r_q[0].x, 511)) begin bad++; $display("FAIL single_x: got %0d expected 511", r_q[0].x); end
    if (!near(r_q[0].y, 0)) begin bad++; $display("FAIL single_y: got %0d expected 0", r_q[0].y); end
  endtask

  task automatic test_round_robin();
    int ang [4] = '{0, 803, 1606, 2409};
    int ex  [4] = '{511, 0, -511, 0};
    int ey  [4] = '{0, 511, 0, -511};
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, ang[i]);
    wait_grants(8, 60, "rr");
    req_valid = '0;
    wait_rsps(8, 4 * LAT, "rr");
    if (g_q.size() < 8 || r_q.size() < 8) return;
    for (int k = 0; k < 8; k++) begin
      total += 5;
      if (g_q[k].id != k % 4) begin bad++; $display("FAIL rr_grant%0d: got id %0d expected %0d", k, g_q[k].id, k % 4); end
      if (g_q[k].cyc != g_q[0].cyc + k) begin
        bad++; $display("FAIL rr_b2b%0d: got cycle %0d expected %0d", k, g_q[k].cyc, g_q[0].cyc + k);
      end
      if (r_q[k].id != k % 4) begin bad++; $display("FAIL rr_rsp_id%0d: got %0d expected %0d", k, r_q[k].id, k % 4); end
      if (!near(r_q[k].x, ex[k%4])) begin bad++; $display("FAIL rr_x%0d: got %0d expected %0d", k, r_q[k].x, ex[k%4]); end
      if (!near(r_q[k].y, ey[k%4])) begin bad++; $display("FAIL rr_y%0d: got %0d expected %0d", k, r_q[k].y, ey[k%4]); end
    end
  endtask

  task automatic test_credits();
    do_reset();
    set_req(0, 1'b1, 100);
    tick(40);
    @(negedge clock);
    total += 2;
    if (g_q.size() != DEPTH) begin bad++; $display("FAIL credit_limit: got %0d grants expected %0d", g_q.size(), DEPTH); end
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL credit_stall: got req_ready=%b expected 0000", req_ready); end
    tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick(10);
    @(negedge clock);
    total += 3;
    if (r_q.size() != 1) begin bad++; $display("FAIL credit_pop: got %0d pops expected 1", r_q.size()); end
    if (g_q.size() != DEPTH + 1) begin bad++; $display("FAIL credit_refill: got %0d grants expected %0d", g_q.size(), DEPTH + 1); end
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL credit_restall: got req_ready=%b expected 0000", req_ready); end
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_rsps(DEPTH + 1, 4 * LAT, "credit_drain");
  endtask

  task automatic test_reset_flush();
    int k = 0;
    do_reset();
    set_req(0, 1'b1, 200);
    wait_grants(DEPTH, 20, "flush");
    req_valid = '0;
    while (!rsp_valid && k < 3 * LAT) begin
      tick();
      k++;
    end
    total++;
    if (!rsp_valid) begin bad++; $display("FAIL flush_fill: got rsp_valid=0 expected 1"); end
    tick(2);
    reset = 1'b1;
    tick();
    @(negedge clock);
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_rsp_valid: got %b expected 0", rsp_valid); end
    @(posedge clock);
    #1;
    reset     = 1'b0;
    rsp_ready = 1'b1;
    r_q.delete();
    g_q.delete();
    tick(2 * LAT);
    total++;
    if (r_q.size() != 0) begin bad++; $display("FAIL flush_stale: got %0d responses expected 0", r_q.size()); end
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 300);
    tick(40);
    total++;
    if (g_q.size() != DEPTH) begin bad++; $display("FAIL flush_credits: got %0d grants expected %0d", g_q.size(), DEPTH); end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_rsps(DEPTH, 4 * LAT, "flush_drain");
  endtask

  task automatic test_wrap();
    int exp_x, exp_y;
`ifdef CORDIC_ANGLE_WRAP_EN
    exp_x = 0;
    exp_y = 511;
`else
    exp_x = -2048;
    exp_y = -2048;
`endif
    do_reset();
    rsp_ready = 1'b1;
    set_req(1, 1'b1, 4015);
    wait_grants(1, 10, "wrap");
    req_valid = '0;
    wait_rsps(1, 3 * LAT, "wrap");
    if (r_q.size() < 1) return;
    total += 3;
    if (r_q[0].id != 1) begin bad++; $display("FAIL wrap_id: got %0d expected 1", r_q[0].id); end
    if (!near(r_q[0].x, exp_x)) begin bad++; $display("FAIL wrap_x: got %0d expected %0d", r_q[0].x, exp_x); end
    if (!near(r_q[0].y, exp_y)) begin bad++; $display("FAIL wrap_y: got %0d expected %0d", r_q[0].y, exp_y); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3211)));
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_rsps(g_q.size(), 4 * LAT + 20, "random");
    total += 2;
    if (g_q.size() < 200) begin bad++; $display("FAIL random_activity: got %0d grants expected >= 200", g_q.size()); end
    if (r_q.size() != g_q.size()) begin
      bad++; $display("FAIL random_count: got %0d responses expected %0d", r_q.size(), g_q.size());
      return;
    end
    for (int k = 0; k < g_q.size(); k++) begin
      int xm = model_val(g_q[k].a, 1'b0);
      int ym = model_val(g_q[k].a, 1'b1);
      total++;
      if (r_q[k].id != g_q[k].id || !near(r_q[k].x, xm) || !near(r_q[k].y, ym)) begin
        bad++;
        $display("FAIL random_rsp%0d: got id=%0d x=%0d y=%0d expected id=%0d x=%0d y=%0d",
                 k, r_q[k].id, r_q[k].x, r_q[k].y, g_q[k].id, xm, ym);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_angle = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_credits();
    test_reset_flush();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
